// File: rtl/timer_cnt_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
//   Shared definitions for the 64-bit timer counter controller slice.
//   - Sizing defaults for the counter, prescale exponent and largest divider.
//   - Bit positions inside counter_write_sel.
//   - Controller state encoding (2-bit).
// ----------------------------------------------------------------------------
package timer_pkg;

    localparam int CNT_W_DEFAULT   = 64;
    localparam int DIV_W_DEFAULT   = 4;
    localparam int MAX_DIV_DEFAULT = 8;

    localparam int WSEL_LO = 0;
    localparam int WSEL_HI = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/timer_cnt_ctrl_prescaler.sv
// ----------------------------------------------------------------------------
// timer_prescaler
//   Divides the RUN cycles of the timer by 2^div_val and emits a tick when the
//   counter should advance. div_val values above MAX_DIV are clamped to
//   MAX_DIV. The phase count holds whenever run is low, so a debug halt does
//   not disturb the division phase.
//
// Ports:
//   sys_clk  in   system clock, rising edge
//   sys_rst  in   synchronous active-high reset
//   run      in   1 while the controller is in RUN
//   clr      in   restart the division phase at 0
//   div_en   in   0: tick every run cycle, 1: divide by 2^div_val
//   div_val  in   prescale exponent (DIV_W bits)
//   tick     out  combinational, 1 in a run cycle that ends a division period
// ----------------------------------------------------------------------------
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEFAULT,
    parameter int MAX_DIV = MAX_DIV_DEFAULT
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             run,
    input  logic             clr,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick
);

    localparam logic [DIV_W-1:0] MAX_DIV_V = DIV_W'(MAX_DIV);

    logic [MAX_DIV-1:0] pre_cnt;
    logic [MAX_DIV-1:0] terminal;
    logic [DIV_W-1:0]   div_sat;
    logic               at_end;

    // Clamp the exponent, then build the terminal count (2^div_sat)-1 as a
    // mask of div_sat low ones, which avoids a variable-width shift.
    always_comb begin
        div_sat = (div_val > MAX_DIV_V) ? MAX_DIV_V : div_val;
        terminal = '0;
        for (int i = 0; i < MAX_DIV; i++) begin
            if (DIV_W'(i) < div_sat) begin
                terminal[i] = 1'b1;
            end
        end
    end

    // ">=" rather than "==" so that lowering div_val mid-period ends the
    // period at once instead of wrapping through the whole MAX_DIV range.
    always_comb begin
        at_end = !div_en || (pre_cnt >= terminal);
        tick   = run && at_end;
    end

    // Phase counter: restarts on clr, advances only while running and
    // returns to 0 at the end of every period.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (run) begin
            if (at_end) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + MAX_DIV'(1);
            end
        end
    end

endmodule

// File: rtl/timer_cnt_ctrl.sv
// ----------------------------------------------------------------------------
// timer_cnt_ctrl
//   Sequencing controller for the timer counter. Owns the CNT_W-bit counter
//   and the prescaler, runs/stops counting from the register-block controls,
//   applies software clear/write commands and reports the live count and the
//   debug-halt acknowledge.
//
//   Optional feature macro: TIMER_CNT_OVF_EN
//     defined   -> cnt_ovf pulses with cnt_tick when an increment wraps to 0
//     undefined -> cnt_ovf is tied to 0 (port still present)
//
// Ports:
//   sys_clk             in   system clock, all state on rising edge
//   sys_rst             in   synchronous active-high reset
//   timer_en            in   counter enable
//   div_en              in   prescaler enable
//   div_val             in   prescale exponent, divide by 2^div_val
//   halt_req            in   debug halt request (level)
//   dbg_mode            in   halt honoured only when 1
//   counter_clear       in   one-cycle clear command
//   counter_write_sel   in   bit0 loads low half, bit1 loads high half
//   counter_write_data  in   load data (CNT_W/2 bits)
//   cnt_val             out  live counter value
//   halt_ack_status     out  1 while counting is frozen by halt
//   cnt_tick            out  registered pulse aligned with each new count
//   cnt_ovf             out  registered wrap pulse (see macro above)
// ----------------------------------------------------------------------------
module timer_cnt_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int DIV_W   = DIV_W_DEFAULT,
    parameter int MAX_DIV = MAX_DIV_DEFAULT
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               timer_en,
    input  logic               div_en,
    input  logic [DIV_W-1:0]   div_val,
    input  logic               halt_req,
    input  logic               dbg_mode,
    input  logic               counter_clear,
    input  logic [1:0]         counter_write_sel,
    input  logic [CNT_W/2-1:0] counter_write_data,
    output logic [CNT_W-1:0]   cnt_val,
    output logic               halt_ack_status,
    output logic               cnt_tick,
    output logic               cnt_ovf
);

    localparam int HALF_W = CNT_W / 2;

    state_t state;
    state_t state_nxt;
    logic   halt_cond;
    logic   halt_ack_q;
    logic   run;
    logic   write_any;
    logic   presc_clr;
    logic   presc_tick;
    logic   inc;

    assign halt_cond = halt_req & dbg_mode;
    assign write_any = |counter_write_sel;

    // State register. The acknowledge is registered from the next state so it
    // lines up exactly with the cycles spent in HALTED.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            halt_ack_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            halt_ack_q <= (state_nxt == ST_HALTED);
        end
    end

    // Next-state logic. Dropping timer_en wins over any halt movement, so a
    // halted timer that is disabled goes straight back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (timer_en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!timer_en) begin
                    state_nxt = ST_IDLE;
                end else if (halt_cond) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!timer_en) begin
                    state_nxt = ST_IDLE;
                end else if (!halt_cond) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode. The prescaler restarts on a fresh start from IDLE and on
    // any software clear/write, so a new count always begins a full period.
    // A clear or write in the same cycle as a tick swallows that increment.
    always_comb begin
        run             = (state == ST_RUN);
        halt_ack_status = halt_ack_q;
        presc_clr       = counter_clear || write_any ||
                          ((state == ST_IDLE) && (state_nxt == ST_RUN));
        inc             = presc_tick && !counter_clear && !write_any;
    end

    timer_prescaler #(
        .DIV_W   (DIV_W),
        .MAX_DIV (MAX_DIV)
    ) u_prescaler (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .run     (run),
        .clr     (presc_clr),
        .div_en  (div_en),
        .div_val (div_val),
        .tick    (presc_tick)
    );

    // Counter register: clear beats write beats increment. Clear and write
    // work in every state; the count is otherwise kept, including in IDLE.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_val  <= '0;
            cnt_tick <= 1'b0;
        end else begin
            cnt_tick <= inc;
            if (counter_clear) begin
                cnt_val <= '0;
            end else if (write_any) begin
                if (counter_write_sel[WSEL_LO]) begin
                    cnt_val[HALF_W-1:0] <= counter_write_data;
                end
                if (counter_write_sel[WSEL_HI]) begin
                    cnt_val[CNT_W-1:HALF_W] <= counter_write_data;
                end
            end else if (inc) begin
                cnt_val <= cnt_val + CNT_W'(1);
            end
        end
    end

`ifdef TIMER_CNT_OVF_EN
    logic ovf_q;

    // Wrap pulse: only a real increment from all-ones raises it, so loads of
    // all-ones or clears never do.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= inc && (&cnt_val);
        end
    end

    assign cnt_ovf = ovf_q;
`else
    assign cnt_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// ----------------------------------------------------------------------------
// tb_timer_cnt_ctrl
//   Self-checking bench for timer_cnt_ctrl. A behavioural model pushes the
//   expected outputs for every clock edge onto a scoreboard queue; each test
//   task pops and compares after the edge, and adds hand-derived checks at
//   the points of interest.
// ----------------------------------------------------------------------------
module tb_timer_cnt_ctrl;

    localparam int CNT_W   = 64;
    localparam int DIV_W   = 4;
    localparam int MAX_DIV = 8;

`ifdef TIMER_CNT_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic             timer_en;
    logic             div_en;
    logic [DIV_W-1:0] div_val;
    logic             halt_req;
    logic             dbg_mode;
    logic             counter_clear;
    logic [1:0]       counter_write_sel;
    logic [31:0]      counter_write_data;
    logic [63:0]      cnt_val;
    logic             halt_ack_status;
    logic             cnt_tick;
    logic             cnt_ovf;

    typedef struct packed {
        logic [63:0] cnt;
        logic        tick;
        logic        ovf;
        logic        ack;
    } obs_t;

    typedef enum int {M_IDLE, M_RUN, M_HALT} mstate_t;

    obs_t        sb[$];
    obs_t        exp_o;
    obs_t        act_o;
    int          checks   = 0;
    int          failures = 0;

    mstate_t     m_state = M_IDLE;
    int          m_pre   = 0;
    logic [63:0] m_cnt   = '0;
    logic        m_tick  = 1'b0;
    logic        m_ovf   = 1'b0;

    timer_cnt_ctrl #(
        .CNT_W   (CNT_W),
        .DIV_W   (DIV_W),
        .MAX_DIV (MAX_DIV)
    ) dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .timer_en           (timer_en),
        .div_en             (div_en),
        .div_val            (div_val),
        .halt_req           (halt_req),
        .dbg_mode           (dbg_mode),
        .counter_clear      (counter_clear),
        .counter_write_sel  (counter_write_sel),
        .counter_write_data (counter_write_data),
        .cnt_val            (cnt_val),
        .halt_ack_status    (halt_ack_status),
        .cnt_tick           (cnt_tick),
        .cnt_ovf            (cnt_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Put every input in its quiet state.
    task automatic drive_idle_inputs();
        sys_rst            = 1'b0;
        timer_en           = 1'b0;
        div_en             = 1'b0;
        div_val            = '0;
        halt_req           = 1'b0;
        dbg_mode           = 1'b0;
        counter_clear      = 1'b0;
        counter_write_sel  = 2'b00;
        counter_write_data = '0;
    endtask

    // Advance the model by one edge with the current inputs, push the
    // expectation, then move to 1 time unit after the edge.
    task automatic drive_cycle();
        int   eff;
        int   term;
        logic halt;
        logic wr;
        logic tick;
        logic inc;
        obs_t e;
        if (sys_rst) begin
            m_state = M_IDLE;
            m_pre   = 0;
            m_cnt   = '0;
            m_tick  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            eff  = (int'(div_val) > MAX_DIV) ? MAX_DIV : int'(div_val);
            term = (1 << eff) - 1;
            halt = halt_req && dbg_mode;
            wr   = (counter_write_sel != 2'b00);
            tick = (m_state == M_RUN) && (!div_en || (m_pre >= term));
            inc  = tick && !counter_clear && !wr;
            if (counter_clear || wr || ((m_state == M_IDLE) && timer_en)) begin
                m_pre = 0;
            end else if (m_state == M_RUN) begin
                m_pre = tick ? 0 : m_pre + 1;
            end
            m_ovf  = OVF_EXP && inc && (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF);
            m_tick = inc;
            if (counter_clear) begin
                m_cnt = '0;
            end else if (wr) begin
                if (counter_write_sel[0]) m_cnt[31:0]  = counter_write_data;
                if (counter_write_sel[1]) m_cnt[63:32] = counter_write_data;
            end else if (inc) begin
                m_cnt = m_cnt + 64'd1;
            end
            case (m_state)
                M_IDLE:  if (timer_en) m_state = M_RUN;
                M_RUN:   if (!timer_en) m_state = M_IDLE;
                         else if (halt) m_state = M_HALT;
                default: if (!timer_en) m_state = M_IDLE;
                         else if (!halt) m_state = M_RUN;
            endcase
        end
        e.cnt  = m_cnt;
        e.tick = m_tick;
        e.ovf  = m_ovf;
        e.ack  = (m_state == M_HALT);
        sb.push_back(e);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle_inputs();
        sys_rst = 1'b1;
        drive_cycle();
        exp_o = sb.pop_front();
        act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
        checks++;
        if (act_o !== exp_o) begin
            failures++;
            $display("[TB] FAIL reset_sb: got %h expected %h", act_o, exp_o);
        end
        checks++;
        if (act_o !== '0) begin
            failures++;
            $display("[TB] FAIL reset_zero: got %h expected 0", act_o);
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_run_free();
        timer_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive_cycle();
            exp_o = sb.pop_front();
            act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
            checks++;
            if (act_o !== exp_o) begin
                failures++;
                $display("[TB] FAIL run_free_c%0d: got %h expected %h", i, act_o, exp_o);
            end
        end
        checks++;
        if ({cnt_val, cnt_tick} !== {64'd10, 1'b1}) begin
            failures++;
            $display("[TB] FAIL run_free_10: got cnt=%0d tick=%b expected cnt=10 tick=1", cnt_val, cnt_tick);
        end
    endtask

    task automatic test_divide();
        drive_idle_inputs();
        sys_rst = 1'b1;
        drive_cycle();
        void'(sb.pop_front());
        sys_rst  = 1'b0;
        timer_en = 1'b1;
        div_en   = 1'b1;
        div_val  = 4'd3;
        for (int i = 0; i < 65; i++) begin
            drive_cycle();
            exp_o = sb.pop_front();
            act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
            checks++;
            if (act_o !== exp_o) begin
                failures++;
                $display("[TB] FAIL div3_c%0d: got %h expected %h", i, act_o, exp_o);
            end
        end
        checks++;
        if (cnt_val !== 64'd8) begin
            failures++;
            $display("[TB] FAIL div3_64cyc: got cnt=%0d expected 8", cnt_val);
        end
        // Two periods of 256: div_val=8, then div_val=15 which clamps to 8.
        for (int pass = 0; pass < 2; pass++) begin
            div_val       = (pass == 0) ? 4'd8 : 4'd15;
            counter_clear = 1'b1;
            drive_cycle();
            counter_clear = 1'b0;
            for (int i = 0; i < 257; i++) begin
                exp_o = sb.pop_front();
                act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
                checks++;
                if (act_o !== exp_o) begin
                    failures++;
                    $display("[TB] FAIL div256_p%0d_c%0d: got %h expected %h", pass, i, act_o, exp_o);
                end
                if (i == 255) begin
                    checks++;
                    if (cnt_val !== 64'd0) begin
                        failures++;
                        $display("[TB] FAIL div256_early_p%0d: got cnt=%0d expected 0", pass, cnt_val);
                    end
                end
                if (i < 256) drive_cycle();
            end
            checks++;
            if ({cnt_val, cnt_tick} !== {64'd1, 1'b1}) begin
                failures++;
                $display("[TB] FAIL div256_p%0d: got cnt=%0d tick=%b expected cnt=1 tick=1", pass, cnt_val, cnt_tick);
            end
        end
    endtask

    task automatic test_halt();
        drive_idle_inputs();
        sys_rst = 1'b1;
        drive_cycle();
        void'(sb.pop_front());
        sys_rst  = 1'b0;
        timer_en = 1'b1;
        div_en   = 1'b1;
        div_val  = 4'd2;
        dbg_mode = 1'b1;
        // 1 entry cycle + 20 RUN cycles reaches 5, then 2 more cycles mid-phase.
        for (int i = 0; i < 23; i++) begin
            drive_cycle();
            exp_o = sb.pop_front();
            act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
            checks++;
            if (act_o !== exp_o) begin
                failures++;
                $display("[TB] FAIL halt_pre_c%0d: got %h expected %h", i, act_o, exp_o);
            end
        end
        halt_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_cycle();
            exp_o = sb.pop_front();
            act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
            checks++;
            if (act_o !== exp_o) begin
                failures++;
                $display("[TB] FAIL halt_hold_c%0d: got %h expected %h", i, act_o, exp_o);
            end
            checks++;
            if ({cnt_val, halt_ack_status} !== {64'd5, 1'b1}) begin
                failures++;
                $display("[TB] FAIL halt_frozen_c%0d: got cnt=%0d ack=%b expected cnt=5 ack=1", i, cnt_val, halt_ack_status);
            end
        end
        halt_req = 1'b0;
        drive_cycle();
        exp_o = sb.pop_front();
        act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
        checks++;
        if (act_o !== {64'd5, 1'b0, 1'b0, 1'b0} || act_o !== exp_o) begin
            failures++;
            $display("[TB] FAIL halt_release: got %h expected %h", act_o, exp_o);
        end
        // One remaining prescale cycle, not a full period of 4.
        drive_cycle();
        exp_o = sb.pop_front();
        act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
        checks++;
        if (act_o !== {64'd6, 1'b1, 1'b0, 1'b0} || act_o !== exp_o) begin
            failures++;
            $display("[TB] FAIL halt_resume_tick: got %h expected %h", act_o, exp_o);
        end
    endtask

    task automatic test_halt_disable();
        halt_req = 1'b1;
        drive_cycle();
        exp_o = sb.pop_front();
        act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
        checks++;
        if (act_o !== {64'd6, 1'b0, 1'b0, 1'b1} || act_o !== exp_o) begin
            failures++;
            $display("[TB] FAIL halt_again: got %h expected %h", act_o, exp_o);
        end
        timer_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_cycle();
            exp_o = sb.pop_front();
            act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
            checks++;
            if (act_o !== {64'd6, 1'b0, 1'b0, 1'b0} || act_o !== exp_o) begin
                failures++;
                $display("[TB] FAIL halt_to_idle_c%0d: got %h expected %h", i, act_o, exp_o);
            end
        end
        halt_req = 1'b0;
    endtask

    task automatic test_wrap();
        drive_idle_inputs();
        sys_rst = 1'b1;
        drive_cycle();
        void'(sb.pop_front());
        sys_rst            = 1'b0;
        counter_write_sel  = 2'b11;
        counter_write_data = 32'hFFFF_FFFF;
        drive_cycle();
        exp_o = sb.pop_front();
        act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
        checks++;
        if (act_o !== {64'hFFFF_FFFF_FFFF_FFFF, 3'b000} || act_o !== exp_o) begin
            failures++;
            $display("[TB] FAIL wrap_load: got %h expected %h", act_o, exp_o);
        end
        counter_write_sel = 2'b00;
        timer_en          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            exp_o = sb.pop_front();
            act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
            checks++;
            if (act_o !== exp_o) begin
                failures++;
                $display("[TB] FAIL wrap_c%0d: got %h expected %h", i, act_o, exp_o);
            end
            if (i == 1) begin
                checks++;
                if ({cnt_val, cnt_tick, cnt_ovf} !== {64'd0, 1'b1, OVF_EXP}) begin
                    failures++;
                    $display("[TB] FAIL wrap_ovf: got cnt=%h tick=%b ovf=%b expected cnt=0 tick=1 ovf=%b", cnt_val, cnt_tick, cnt_ovf, OVF_EXP);
                end
            end
        end
    endtask

    task automatic test_priority();
        counter_clear      = 1'b1;
        counter_write_sel  = 2'b01;
        counter_write_data = 32'h0000_1234;
        drive_cycle();
        exp_o = sb.pop_front();
        act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
        checks++;
        if (act_o !== {64'd0, 3'b000} || act_o !== exp_o) begin
            failures++;
            $display("[TB] FAIL clear_beats_write: got %h expected %h", act_o, exp_o);
        end
        counter_clear = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sels [3]  = '{2'b01, 2'b10, 2'b00};
        logic [31:0] datas [3] = '{32'hAABB_CCDD, 32'h1111_2222, 32'h0};
        logic [63:0] want [3]  = '{64'h0000_0000_AABB_CCDD, 64'h1111_2222_AABB_CCDD,
                                   64'h1111_2222_AABB_CCDE};
        for (int i = 0; i < 3; i++) begin
            counter_write_sel  = sels[i];
            counter_write_data = datas[i];
            drive_cycle();
            exp_o = sb.pop_front();
            act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
            checks++;
            if (act_o !== {want[i], (i == 2), 2'b00} || act_o !== exp_o) begin
                failures++;
                $display("[TB] FAIL b2b_write_c%0d: got %h expected %h", i, act_o, exp_o);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        sys_rst = 1'b1;
        drive_cycle();
        exp_o = sb.pop_front();
        act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
        checks++;
        if (act_o !== '0 || act_o !== exp_o) begin
            failures++;
            $display("[TB] FAIL mid_reset: got %h expected 0", act_o);
        end
        sys_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_cycle();
            exp_o = sb.pop_front();
            act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
            checks++;
            if (act_o !== {64'(i), (i == 1), 2'b00} || act_o !== exp_o) begin
                failures++;
                $display("[TB] FAIL mid_reset_restart_c%0d: got %h expected %h", i, act_o, exp_o);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            sys_rst            = ($urandom_range(0, 99) == 0);
            timer_en           = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 15) == 0) div_en  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) div_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)  halt_req = ~halt_req;
            dbg_mode           = ($urandom_range(0, 3) != 0);
            counter_clear      = ($urandom_range(0, 29) == 0);
            counter_write_sel  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            counter_write_data = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            drive_cycle();
            exp_o = sb.pop_front();
            act_o = {cnt_val, cnt_tick, cnt_ovf, halt_ack_status};
            checks++;
            if (act_o !== exp_o) begin
                failures++;
                $display("[TB] FAIL random_c%0d: got %h expected %h", i, act_o, exp_o);
            end
        end
    endtask

    initial begin
        drive_idle_inputs();
        test_reset();
        test_run_free();
        test_divide();
        test_halt();
        test_halt_disable();
        test_wrap();
        test_priority();
        test_back_to_back();
        test_reset_mid_run();
        drive_idle_inputs();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
